alu_mc: RTL and testbench

// - Parametrised multi-cycle ALU: next generation of the 8-op ALU (and/or/xor/nor/slt/add/sub/mod).
// - Adds a start/busy/done handshake, a configurable width, latched operands and a bit-serial restoring modulo unit.
// - Sits between the register-file read stage and writeback; the controller stalls on busy.

---
 rtl/alu_mc.sv | 173 +++++++++++++++++
 tb/tb_alu_mc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 8 ops with a start/busy/done handshake and a bit-serial mod unit.
// Define ALU_OVF_EN to add the signed-overflow output for add/sub.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_bit
`ifdef ALU_OVF_EN
  , output logic           overflow
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, MOD_RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
`ifdef ALU_OVF_EN
  logic             ovf_q, ovf_d;
  logic             ovf_op;
`endif

  logic [WIDTH-1:0] sum, diff, op_res, rest;

  always_comb begin
    sum  = a_q + b_q;
    diff = a_q - b_q;
    op_res = a_q;
    unique case (sel_q)
      3'd0: op_res = a_q & b_q;
      3'd1: op_res = a_q | b_q;
      3'd2: op_res = a_q ^ b_q;
      3'd3: op_res = ~(a_q | b_q);
      3'd4: op_res = {{(WIDTH-1){1'b0}},
                      $signed(a_q) < $signed(b_q)};
      3'd5: op_res = sum;
      3'd6: op_res = diff;
      3'd7: op_res = a_q;
      default: op_res = a_q;
    endcase
  end

`ifdef ALU_OVF_EN
  always_comb begin
    ovf_op = 1'b0;
    if (sel_q == 3'd5)
      ovf_op = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
               (sum[WIDTH-1] != a_q[WIDTH-1]);
    else if (sel_q == 3'd6)
      ovf_op = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
               (diff[WIDTH-1] != a_q[WIDTH-1]);
  end
`endif

  // rem_q holds the shifted partial remainder; subtract b when it fits.
  always_comb begin
    rest = rem_q[WIDTH-1:0];
    if (rem_q >= {1'b0, b_q})
      rest = WIDTH'(rem_q - {1'b0, b_q});
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
`ifdef ALU_OVF_EN
    ovf_d   = ovf_q;
`endif
    busy = (state_q == EXEC) || (state_q == MOD_RUN);
    done = (state_q == FIN);
    unique case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          a_d   = a;
          b_d   = b;
          sel_d = sel;
          if (sel == 3'd7 && b != '0) begin
            state_d = MOD_RUN;
            rem_d   = {{WIDTH{1'b0}}, a[WIDTH-1]};
            dvd_d   = a << 1;
            cnt_d   = CNT_W'(WIDTH);
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d = FIN;
        res_d   = op_res;
        zero_d  = (op_res == '0);
`ifdef ALU_OVF_EN
        ovf_d   = ovf_op;
`endif
      end
      MOD_RUN: begin
        if (cnt_q == '0) begin
          state_d = FIN;
          res_d   = rem_q[WIDTH-1:0];
          zero_d  = (rem_q[WIDTH-1:0] == '0);
`ifdef ALU_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
          dvd_d = dvd_q << 1;
          if (cnt_q == CNT_W'(1))
            rem_d = {1'b0, rest};
          else
            rem_d = {rest, dvd_q[WIDTH-1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
`ifdef ALU_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
`ifdef ALU_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign result   = res_q;
  assign zero_bit = zero_q;
`ifdef ALU_OVF_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: 32-bit instance plus an 8-bit instance for mod timing.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   sel = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, zero_bit;
  logic [W-1:0] result;
`ifdef ALU_OVF_EN
  logic         overflow, s8_ovf;
`endif

  logic         s8_start = 1'b0;
  logic [2:0]   s8_sel = '0;
  logic [7:0]   s8_a = '0, s8_b = '0;
  logic         s8_busy, s8_done, s8_zero;
  logic [7:0]   s8_res;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel),
    .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .zero_bit(zero_bit)
`ifdef ALU_OVF_EN
    , .overflow(overflow)
`endif
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .sel(s8_sel),
    .a(s8_a), .b(s8_b), .busy(s8_busy), .done(s8_done),
    .result(s8_res), .zero_bit(s8_zero)
`ifdef ALU_OVF_EN
    , .overflow(s8_ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    int           when;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [2:0] s, logic [W-1:0] x,
                                 logic [W-1:0] y, string tag);
    exp_t e;
    e.tag = tag;
    e.ovf = 1'b0;
    e.when = 0;
    case (s)
      3'd0: e.res = x & y;
      3'd1: e.res = x | y;
      3'd2: e.res = x ^ y;
      3'd3: e.res = ~(x | y);
      3'd4: e.res = ($signed(x) < $signed(y)) ? 1 : 0;
      3'd5: begin
        e.res = x + y;
        e.ovf = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      3'd6: begin
        e.res = x - y;
        e.ovf = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      default: e.res = (y == 0) ? x : x % y;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic issue(logic [2:0] s, logic [W-1:0] x,
                       logic [W-1:0] y, string tag, bit hold);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      chk({tag, "_idle_timeout"}, busy, 0);
      return;
    end
    start = 1'b1;
    sel = s;
    a = x;
    b = y;
    e = model(s, x, y, tag);
    e.when = cyc + ((s == 3'd7 && y != 0) ? W + 2 : 2);
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic drain(string tag);
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  task automatic run8(logic [7:0] x, logic [7:0] y, logic [7:0] er,
                      int elat, string tag);
    int n;
    @(negedge clk);
    s8_start = 1'b1;
    s8_sel = 3'd7;
    s8_a = x;
    s8_b = y;
    @(negedge clk);
    s8_start = 1'b0;
    n = 1;
    while (!s8_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_res"}, s8_res, er);
    chk({tag, "_zero"}, s8_zero, er == 0);
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      chk("done_busy", busy, 0);
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_res"}, result, mon_e.res);
        chk({mon_e.tag, "_zero"}, zero_bit, mon_e.zero);
        chk({mon_e.tag, "_lat"}, cyc, mon_e.when);
`ifdef ALU_OVF_EN
        chk({mon_e.tag, "_ovf"}, overflow, mon_e.ovf);
`endif
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_zero", zero_bit, 1);
    chk("rst8_zero", s8_zero, 1);
`ifdef ALU_OVF_EN
    chk("rst_ovf", overflow, 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      issue(3'(i), 10, 3, $sformatf("op%0d", i), 0);
    drain("ops");

    issue(3'd7, 10, 3, "mod10_3", 0);
    drain("mod10_3");
    issue(3'd7, 9, 3, "mod9_3", 0);
    drain("mod9_3");
    issue(3'd7, 32'h1234, 0, "modz", 0);
    drain("modz");

    issue(3'd7, 100, 7, "mod_ign", 0);
    a = 32'hFFFF;
    b = 32'h1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    sel = 3'd1;
    @(negedge clk);
    start = 1'b0;
    drain("mod_ign");

    issue(3'd7, 1000, 13, "mod_rst", 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    sb.delete();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_res", result, 0);
    chk("midrst_zero", zero_bit, 1);
`ifdef ALU_OVF_EN
    chk("midrst_ovf", overflow, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'd7, 1000, 13, "post_rst", 0);
    drain("post_rst");

    issue(3'd5, 32'hFFFFFFFF, 2, "b2b_add", 1);
    issue(3'd6, 5, 9, "b2b_sub", 1);
    issue(3'd7, 77, 10, "b2b_mod", 1);
    issue(3'd4, 32'h80000000, 1, "b2b_slt", 1);
    issue(3'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, "b2b_nor", 0);
    drain("b2b");

    for (int i = 0; i < 24; i++) begin
      logic [2:0]   rs;
      logic [W-1:0] ra, rb;
      rs = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 3 == 0) ? W'($urandom_range(0, 300)) : $urandom;
      issue(rs, ra, rb, $sformatf("rnd%0d", i), 0);
    end
    drain("rnd");

    issue(3'd5, 32'h7FFFFFFF, 1, "ovf_add", 0);
    issue(3'd0, 32'h7FFFFFFF, 1, "ovf_and", 0);
    issue(3'd6, 32'h80000000, 1, "ovf_sub", 0);
    drain("ovf");

    run8(8'd200, 8'd7, 8'd4, 10, "w8_mod");
    run8(8'd9, 8'd3, 8'd0, 10, "w8_mod0");
    run8(8'd200, 8'd0, 8'd200, 2, "w8_modz");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
